// File: rtl/puf_key_pkg.sv
// Shared types and sizing helpers for the PUF-to-key derivation block.
package puf_key_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_VOTE,
      ST_DONE,
      ST_ERR
   } state_e;

   function automatic int nchunk(input int key_w, input int resp_w);
      return key_w / resp_w;
   endfunction

   // Width of an index that counts 0..n-1; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic bit cfg_ok(input int key_w, input int resp_w, input int votes);
      return (resp_w > 0) && (key_w % resp_w == 0) && (votes % 2 == 1) &&
             (votes >= 1) && (votes <= 7);
   endfunction

endpackage

// File: rtl/puf_key_gen_vote.sv
// Per-bit saturating vote counters; voted chunk and non-unanimous popcount are
// combinational from the counter state.
module puf_majority_vote #(
   parameter int RESP_W = 16,
   parameter int VOTES  = 3
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        acc,
   input  logic                        clr,
   input  logic [RESP_W-1:0]           sample,
   output logic [RESP_W-1:0]           voted,
   output logic [$clog2(RESP_W+1)-1:0] nonuni
);
   localparam int CNT_W = $clog2(VOTES + 1);
   localparam int POP_W = $clog2(RESP_W + 1);

   logic [CNT_W-1:0] cnt_q [RESP_W];
   logic [CNT_W-1:0] cnt_d [RESP_W];

   always_comb begin
      for (int i = 0; i < RESP_W; i++) begin
         cnt_d[i] = cnt_q[i];
         if (clr) begin
            cnt_d[i] = '0;
         end else if (acc && sample[i] && (cnt_q[i] != CNT_W'(VOTES))) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      voted  = '0;
      nonuni = '0;
      for (int i = 0; i < RESP_W; i++) begin
         voted[i] = (cnt_q[i] > CNT_W'(VOTES / 2));
         if ((cnt_q[i] != '0) && (cnt_q[i] != CNT_W'(VOTES))) begin
            nonuni = nonuni + POP_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RESP_W; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < RESP_W; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: rtl/puf_key_gen.sv
// Majority-voted PUF key derivation feeding the ASCON key input.
// Key/error appear one cycle after DONE/ERR entry; PUF side stalls freely on puf_valid.
module puf_key_gen
   import puf_key_pkg::*;
#(
   parameter int RESP_W    = 16,
   parameter int KEY_W     = 128,
   parameter int VOTES     = 3,
   parameter int TIMEOUT   = 255,
   parameter int MAX_FLIPS = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       clear,
   output logic                       puf_req,
   input  logic                       puf_valid,
   input  logic [RESP_W-1:0]          puf_response,
   output logic [KEY_W-1:0]           ascon_key,
   output logic                       key_valid,
   output logic                       busy,
   output logic                       error,
   output logic [$clog2(KEY_W+1)-1:0] flip_count
);
   localparam int NCHUNK  = nchunk(KEY_W, RESP_W);
   localparam int CHUNK_W = idx_w(NCHUNK);
   localparam int VIDX_W  = idx_w(VOTES);
   localparam int TO_W    = $clog2(TIMEOUT + 1);
   localparam int FLIP_W  = $clog2(KEY_W + 1);
   localparam int POP_W   = $clog2(RESP_W + 1);

   if (!cfg_ok(KEY_W, RESP_W, VOTES)) begin : g_bad_cfg
      $error("puf_key_gen: KEY_W must be a multiple of RESP_W and VOTES odd in 1..7");
   end

   state_e              state_q, state_d;
   logic [KEY_W-1:0]    shift_q, shift_d;
   logic [KEY_W-1:0]    key_q, key_d;
   logic                key_valid_q, key_valid_d;
   logic                error_q, error_d;
   logic [FLIP_W-1:0]   flip_q, flip_d, flip_sum;
   logic [CHUNK_W-1:0]  chunk_q, chunk_d;
   logic [VIDX_W-1:0]   vidx_q, vidx_d;
   logic [TO_W-1:0]     idle_q, idle_d;
   logic                mv_acc, mv_clr, accept;
   logic [RESP_W-1:0]   voted;
   logic [POP_W-1:0]    nonuni;

   puf_majority_vote #(.RESP_W(RESP_W), .VOTES(VOTES)) u_vote (
      .clk    (clk),
      .rst_n  (rst_n),
      .acc    (mv_acc),
      .clr    (mv_clr),
      .sample (puf_response),
      .voted  (voted),
      .nonuni (nonuni)
   );

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      flip_d   = flip_q;
      chunk_d  = chunk_q;
      vidx_d   = vidx_q;
      idle_d   = idle_q;
      mv_acc   = 1'b0;
      mv_clr   = 1'b0;
      accept   = (state_q == ST_WAIT) && puf_valid;
      flip_sum = flip_q + FLIP_W'(nonuni);

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_WAIT;
               shift_d = '0;
               flip_d  = '0;
               chunk_d = '0;
               vidx_d  = '0;
               idle_d  = '0;
               mv_clr  = 1'b1;
            end
         end
         ST_WAIT: begin
            if (accept) begin
               mv_acc = 1'b1;
               idle_d = '0;
               if (vidx_q == VIDX_W'(VOTES - 1)) state_d = ST_VOTE;
               else                              vidx_d  = vidx_q + 1'b1;
            end else if (idle_q == TO_W'(TIMEOUT - 1)) begin
               state_d = ST_ERR;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         ST_VOTE: begin
            flip_d  = flip_sum;
            shift_d = (shift_q << RESP_W) | KEY_W'(voted);
            mv_clr  = 1'b1;
            vidx_d  = '0;
            idle_d  = '0;
            if (chunk_q == CHUNK_W'(NCHUNK - 1)) begin
               state_d = (int'(flip_sum) <= MAX_FLIPS) ? ST_DONE : ST_ERR;
            end else begin
               chunk_d = chunk_q + 1'b1;
               state_d = ST_WAIT;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear) begin
         state_d = ST_IDLE;
         shift_d = '0;
         flip_d  = '0;
         chunk_d = '0;
         vidx_d  = '0;
         idle_d  = '0;
         mv_acc  = 1'b0;
         mv_clr  = 1'b1;
      end

      // Outputs follow the state one cycle late, so the key is captured only once complete.
      key_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
      error_d     = (state_q == ST_ERR) && (state_d == ST_ERR);
      key_d       = key_valid_d ? (key_valid_q ? key_q : shift_q) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         error_q     <= 1'b0;
         flip_q      <= '0;
         chunk_q     <= '0;
         vidx_q      <= '0;
         idle_q      <= '0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         error_q     <= error_d;
         flip_q      <= flip_d;
         chunk_q     <= chunk_d;
         vidx_q      <= vidx_d;
         idle_q      <= idle_d;
      end
   end

   assign puf_req    = (state_q == ST_WAIT);
   assign busy       = (state_q == ST_WAIT) || (state_q == ST_VOTE);
   assign ascon_key  = key_q;
   assign key_valid  = key_valid_q;
   assign error      = error_q;
   assign flip_count = flip_q;

endmodule
